// File: rtl/ov7670_frame_source_if.sv
// rtl/ov7670_frame_source_if.sv - DVP pin bundle between the synthetic camera and its consumer
// Signals:
//   cam_pclk  - pixel clock
//   cam_vsync - frame sync
//   cam_href  - line valid
//   cam_data  - pixel byte
// Modports: master drives the pins (frame source), slave observes them (capture side).
interface ov7670_frame_source_if;
  logic       cam_pclk;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_data;

  modport master (
    output cam_pclk,
    output cam_vsync,
    output cam_href,
    output cam_data
  );

  modport slave (
    input cam_pclk,
    input cam_vsync,
    input cam_href,
    input cam_data
  );
endinterface

// File: rtl/ov7670_frame_source.sv
// rtl/ov7670_frame_source.sv - synthetic OV7670-style DVP transmitter producing RGB565 test frames
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   ena               - clock enable; low freezes every register and output
//   start             - single-frame request, honoured only when idle
//   continuous        - sampled at frame end; high chains the next frame with no gap
//   mode              - pattern: 0 solid, 1 colour bars, 2 plant, 3 ramp
//   color565          - solid / background colour
//   green_top         - first green row in plant mode
//   dvp (master)      - cam_pclk, cam_vsync, cam_href, cam_data
//   busy              - high from frame start until return to idle
//   frame_done        - one-clk pulse on the last tick of every frame
//   frame_count       - completed frames, wraps at 8 bits
module ov7670_frame_source #(
  parameter int H_ACTIVE = 16,
  parameter int V_ACTIVE = 8,
  parameter int H_BLANK  = 4,
  parameter int VSYNC_W  = 3,
  parameter int V_BACK   = 2,
  parameter int V_FRONT  = 2,
  parameter int VS_MODE  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          start,
  input  logic                          continuous,
  input  logic [1:0]                    mode,
  input  logic [15:0]                   color565,
  input  logic [7:0]                    green_top,
  ov7670_frame_source_if.master         dvp,
  output logic                          busy,
  output logic                          frame_done,
  output logic [7:0]                    frame_count
);

  localparam int CW = 16;
  localparam int CB = $clog2(H_ACTIVE);

  localparam logic [CW-1:0] VS_LAST  = CW'(VSYNC_W - 1);
  localparam logic [CW-1:0] VB_LAST  = CW'(V_BACK - 1);
  localparam logic [CW-1:0] LN_LAST  = CW'(2 * H_ACTIVE - 1);
  localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VF_LAST  = CW'(V_FRONT - 1);
  localparam logic [7:0]    ROW_LAST = 8'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_LINE,
    S_HBLANK,
    S_VFRONT
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [7:0]     row, row_n;

  logic           pclk_q, vsync_q, href_q;
  logic [7:0]     data_q;

  logic [1:0]     mode_q;
  logic [15:0]    color_q;
  logic [7:0]     gt_q;

  logic           tick, start_idle, last_tick, relatch, update;
  logic           vsync_n, href_n;
  logic [7:0]     data_n;
  logic [CW-1:0]  col;
  logic [2:0]     bar;
  logic [15:0]    pix;

  assign dvp.cam_pclk  = pclk_q;
  assign dvp.cam_vsync = vsync_q;
  assign dvp.cam_href  = href_q;
  assign dvp.cam_data  = data_q;

  // pclk is only ever high while busy, so a high pclk marks the falling half of a byte.
  assign tick       = ena & pclk_q;
  assign start_idle = ena & start & (state == S_IDLE);
  assign relatch    = start_idle | (last_tick & continuous);
  assign update     = start_idle | tick;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    row_n     = row;
    last_tick = 1'b0;
    if (start_idle) begin
      state_n = S_VSYNC;
      cnt_n   = '0;
      row_n   = '0;
    end else if (tick) begin
      cnt_n = cnt + 16'd1;
      case (state)
        S_VSYNC: begin
          if (cnt == VS_LAST) begin
            state_n = S_VBACK;
            cnt_n   = '0;
          end
        end
        S_VBACK: begin
          if (cnt == VB_LAST) begin
            state_n = S_LINE;
            cnt_n   = '0;
            row_n   = '0;
          end
        end
        S_LINE: begin
          if (cnt == LN_LAST) begin
            state_n = S_HBLANK;
            cnt_n   = '0;
          end
        end
        S_HBLANK: begin
          if (cnt == HB_LAST) begin
            cnt_n = '0;
            if (row == ROW_LAST) begin
              state_n = S_VFRONT;
            end else begin
              state_n = S_LINE;
              row_n   = row + 8'd1;
            end
          end
        end
        S_VFRONT: begin
          if (cnt == VF_LAST) begin
            last_tick = 1'b1;
            cnt_n     = '0;
            row_n     = '0;
            state_n   = continuous ? S_VSYNC : S_IDLE;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Pixel for the byte about to be presented: in LINE the counter is the byte index.
  always_comb begin
    col = cnt_n >> 1;
    bar = 3'(col >> (CB - 3));
    case (mode_q)
      2'd0: pix = color_q;
      2'd1: begin
        case (bar)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd2:    pix = (row_n >= gt_q) ? 16'h07E0 : color_q;
      default: pix = {row_n[4:0], col[5:0], 5'b0};
    endcase
  end

  always_comb begin
    href_n = (state_n == S_LINE);
    if (VS_MODE == 0) begin
      vsync_n = (state_n == S_VSYNC);
    end else begin
      vsync_n = (state_n == S_VSYNC) || (state_n == S_VBACK) ||
                (state_n == S_LINE)  || (state_n == S_HBLANK);
    end
    data_n = href_n ? (cnt_n[0] ? pix[7:0] : pix[15:8]) : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      row         <= '0;
      pclk_q      <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= 8'h00;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'h00;
      mode_q      <= 2'd0;
      color_q     <= 16'h0000;
      gt_q        <= 8'h00;
    end else if (ena) begin
      frame_done <= last_tick;
      if (busy) begin
        pclk_q <= ~pclk_q;
      end
      if (update) begin
        state   <= state_n;
        cnt     <= cnt_n;
        row     <= row_n;
        vsync_q <= vsync_n;
        href_q  <= href_n;
        data_q  <= data_n;
        busy    <= (state_n != S_IDLE);
      end
      if (last_tick) begin
        frame_count <= frame_count + 8'd1;
      end
      if (relatch) begin
        mode_q  <= mode;
        color_q <= color565;
        gt_q    <= green_top;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_frame_source.sv
// tb/tb_ov7670_frame_source.sv - self-checking bench for ov7670_frame_source
module tb_ov7670_frame_source;

  localparam int TB_H = 16;
  localparam int TB_V = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] color565 = 16'h0000;
  logic [7:0]  green_top = 8'h00;
  logic        busy, frame_done;
  logic [7:0]  frame_count;

  logic        rst_f = 1'b1;
  logic        ena_f = 1'b1;
  logic        start_f = 1'b0;
  logic        cont_f = 1'b0;
  logic [1:0]  mode_f = 2'd0;
  logic [15:0] color_f = 16'hA5C3;
  logic [7:0]  gt_f = 8'h00;
  logic        busy_f, frame_done_f;
  logic [7:0]  frame_count_f;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs[$];
  int rise_cnt = 0;
  int href_pulses = 0;
  int vs_ticks = 0;
  logic mon_prev_pclk = 1'b0;
  logic mon_prev_href = 1'b0;

  ov7670_frame_source_if dvp();
  ov7670_frame_source_if dvp_f();

  ov7670_frame_source u_dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .start       (start),
    .continuous  (continuous),
    .mode        (mode),
    .color565    (color565),
    .green_top   (green_top),
    .dvp         (dvp),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  ov7670_frame_source #(
    .H_ACTIVE (8),
    .V_ACTIVE (2),
    .H_BLANK  (1),
    .VSYNC_W  (1),
    .V_BACK   (1),
    .V_FRONT  (1),
    .VS_MODE  (1)
  ) u_fast (
    .clk         (clk),
    .rst         (rst_f),
    .ena         (ena_f),
    .start       (start_f),
    .continuous  (cont_f),
    .mode        (mode_f),
    .color565    (color_f),
    .green_top   (gt_f),
    .dvp         (dvp_f),
    .busy        (busy_f),
    .frame_done  (frame_done_f),
    .frame_count (frame_count_f)
  );

  always #5 clk = ~clk;

  // Byte capture on cam_pclk rising edges of the main instance, sampled at clk negedge.
  always @(negedge clk) begin
    if (dvp.cam_pclk && !mon_prev_pclk) begin
      rise_cnt++;
      if (dvp.cam_vsync) vs_ticks++;
      if (dvp.cam_href) begin
        obs.push_back(dvp.cam_data);
        if (!mon_prev_href) href_pulses++;
      end
      mon_prev_href = dvp.cam_href;
    end
    mon_prev_pclk = dvp.cam_pclk;
  end

  function automatic logic [15:0] model_pix(input logic [1:0] m, input logic [15:0] c,
                                            input logic [7:0] gt, input int r, input int cl);
    int b;
    case (m)
      2'd0: model_pix = c;
      2'd1: begin
        b = (cl * 8) / TB_H;
        case (b)
          0: model_pix = 16'hFFFF;
          1: model_pix = 16'hFFE0;
          2: model_pix = 16'h07FF;
          3: model_pix = 16'h07E0;
          4: model_pix = 16'hF81F;
          5: model_pix = 16'hF800;
          6: model_pix = 16'h001F;
          default: model_pix = 16'h0000;
        endcase
      end
      2'd2: model_pix = (r >= int'(gt)) ? 16'h07E0 : c;
      default: model_pix = 16'(((r % 32) << 11) | ((cl % 64) << 5));
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] m, input logic [15:0] c, input logic [7:0] gt);
    logic [15:0] p;
    for (int r = 0; r < TB_V; r++) begin
      for (int cl = 0; cl < TB_H; cl++) begin
        p = model_pix(m, c, gt, r, cl);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
    end
  endtask

  task automatic start_and_wait(output int fd_cyc, output bit to);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    fd_cyc = -1;
    to = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (frame_done && fd_cyc < 0) fd_cyc = c;
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({busy, frame_done, dvp.cam_pclk, dvp.cam_vsync, dvp.cam_href} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=00000", {busy, frame_done, dvp.cam_pclk, dvp.cam_vsync, dvp.cam_href});
    end
    total++;
    if (dvp.cam_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data got=%h want=00", dvp.cam_data);
    end
    total++;
    if (frame_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", frame_count);
    end
  endtask

  task automatic test_solid();
    int fd_cyc; bit to; int nb; int first; logic [7:0] o, e;
    mode = 2'd0; color565 = 16'hF800; green_top = 8'h00;
    obs.delete(); exp_q.delete();
    rise_cnt = 0; href_pulses = 0; vs_ticks = 0;
    push_frame(2'd0, 16'hF800, 8'h00);
    start_and_wait(fd_cyc, to);
    total++;
    if (to) begin bad++; $display("FAIL solid_timeout got=busy_stuck want=idle"); end
    total++;
    if (fd_cyc !== 590) begin bad++; $display("FAIL solid_fd_latency got=%0d want=590", fd_cyc); end
    total++;
    if (rise_cnt !== 295) begin bad++; $display("FAIL solid_pclk_rises got=%0d want=295", rise_cnt); end
    total++;
    if (href_pulses !== 8) begin bad++; $display("FAIL solid_href_pulses got=%0d want=8", href_pulses); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL solid_busy_after got=%b want=0", busy); end
    total++;
    if (frame_count !== 8'd1) begin bad++; $display("FAIL solid_count got=%0d want=1", frame_count); end
    total++;
    if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL solid_len got=%0d want=%0d", obs.size(), exp_q.size()); end
    nb = 0; first = -1;
    for (int i = 0; obs.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin nb++; if (first < 0) first = i; end
    end
    total++;
    if (nb !== 0) begin bad++; $display("FAIL solid_bytes got=%0d_mismatches(first@%0d) want=0", nb, first); end
  endtask

  task automatic test_plant();
    int fd_cyc; bit to; int nb; int first; logic [7:0] o, e;
    mode = 2'd2; color565 = 16'h0000; green_top = 8'd5;
    obs.delete(); exp_q.delete();
    push_frame(2'd2, 16'h0000, 8'd5);
    start_and_wait(fd_cyc, to);
    total++;
    if (to) begin bad++; $display("FAIL plant_timeout got=busy_stuck want=idle"); end
    total++;
    if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL plant_len got=%0d want=%0d", obs.size(), exp_q.size()); end
    nb = 0; first = -1;
    for (int i = 0; obs.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin nb++; if (first < 0) first = i; end
    end
    total++;
    if (nb !== 0) begin bad++; $display("FAIL plant_bytes got=%0d_mismatches(first@%0d) want=0", nb, first); end
  endtask

  task automatic test_bars();
    int fd_cyc; bit to; int nb; int first; logic [7:0] o, e;
    mode = 2'd1; color565 = 16'h1234; green_top = 8'h00;
    obs.delete(); exp_q.delete();
    vs_ticks = 0;
    push_frame(2'd1, 16'h1234, 8'h00);
    start_and_wait(fd_cyc, to);
    total++;
    if (to) begin bad++; $display("FAIL bars_timeout got=busy_stuck want=idle"); end
    total++;
    if (vs_ticks !== 3) begin bad++; $display("FAIL bars_vsync_width got=%0d want=3", vs_ticks); end
    total++;
    if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL bars_len got=%0d want=%0d", obs.size(), exp_q.size()); end
    nb = 0; first = -1;
    for (int i = 0; obs.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin nb++; if (first < 0) first = i; end
    end
    total++;
    if (nb !== 0) begin bad++; $display("FAIL bars_bytes got=%0d_mismatches(first@%0d) want=0", nb, first); end
  endtask

  task automatic test_midframe_inputs();
    int fd_cyc; bit to; int nb; int first; int fc0; logic [7:0] o, e;
    fc0 = int'(frame_count);
    mode = 2'd0; color565 = 16'h001F; green_top = 8'h00;
    obs.delete(); exp_q.delete();
    push_frame(2'd0, 16'h001F, 8'h00);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (200) @(negedge clk);
    mode = 2'd2; color565 = 16'hFFFF; green_top = 8'd8;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
    end
    total++;
    if (to) begin bad++; $display("FAIL mid_timeout got=busy_stuck want=idle"); end
    nb = 0; first = -1;
    total++;
    if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL mid_len got=%0d want=%0d", obs.size(), exp_q.size()); end
    for (int i = 0; obs.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin nb++; if (first < 0) first = i; end
    end
    total++;
    if (nb !== 0) begin bad++; $display("FAIL mid_cur_frame got=%0d_mismatches(first@%0d) want=0", nb, first); end
    repeat (6) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_start_ignored got=busy%b want=busy0", busy); end
    total++;
    if (frame_count !== 8'(fc0 + 1)) begin bad++; $display("FAIL mid_count got=%0d want=%0d", frame_count, fc0 + 1); end
    obs.delete(); exp_q.delete();
    push_frame(2'd2, 16'hFFFF, 8'd8);
    start_and_wait(fd_cyc, to);
    total++;
    if (to) begin bad++; $display("FAIL mid_next_timeout got=busy_stuck want=idle"); end
    nb = 0; first = -1;
    for (int i = 0; obs.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin nb++; if (first < 0) first = i; end
    end
    total++;
    if (nb !== 0 || exp_q.size() !== 0) begin
      bad++; $display("FAIL mid_next_frame got=%0d_mismatches(first@%0d) want=0", nb, first);
    end
  endtask

  task automatic test_ena_freeze();
    int cyc; int fd_cyc; int fz_bad; int nb; int first; bit found; bit to;
    logic [11:0] snap; logic [7:0] o, e;
    mode = 2'd3; color565 = 16'h0000; green_top = 8'h00;
    obs.delete(); exp_q.delete();
    push_frame(2'd3, 16'h0000, 8'h00);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; found = 1'b0; fd_cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); cyc++;
      if (obs.size() >= 7 && dvp.cam_href) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL ena_reach_line got=not_found want=href"); end
    snap = {busy, dvp.cam_pclk, dvp.cam_vsync, dvp.cam_href, dvp.cam_data};
    ena = 1'b0;
    fz_bad = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); cyc++;
      if ({busy, dvp.cam_pclk, dvp.cam_vsync, dvp.cam_href, dvp.cam_data} !== snap) fz_bad++;
    end
    ena = 1'b1;
    total++;
    if (fz_bad !== 0) begin bad++; $display("FAIL ena_frozen got=%0d_changes want=0", fz_bad); end
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); cyc++;
      if (frame_done && fd_cyc < 0) fd_cyc = cyc;
      if (!busy) begin to = 1'b0; break; end
    end
    total++;
    if (to || fd_cyc !== 597) begin bad++; $display("FAIL ena_fd_latency got=%0d want=597", fd_cyc); end
    total++;
    if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL ena_len got=%0d want=%0d", obs.size(), exp_q.size()); end
    nb = 0; first = -1;
    for (int i = 0; obs.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin nb++; if (first < 0) first = i; end
    end
    total++;
    if (nb !== 0) begin bad++; $display("FAIL ena_bytes got=%0d_mismatches(first@%0d) want=0", nb, first); end
  endtask

  task automatic test_continuous();
    int rises, hi, lo, falls, fall_bad, fd, busy_gap, data_bad, since_href;
    bit to; logic prev_pf, prev_vs, par;
    mode_f = 2'd0; color_f = 16'hA5C3; cont_f = 1'b1;
    @(negedge clk); start_f = 1'b1;
    @(negedge clk); start_f = 1'b0;
    rises = 0; hi = 0; lo = 0; falls = 0; fall_bad = 0; fd = 0; busy_gap = 0;
    data_bad = 0; since_href = 0; par = 1'b0;
    prev_pf = dvp_f.cam_pclk; prev_vs = dvp_f.cam_vsync;
    to = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (dvp_f.cam_pclk && !prev_pf) begin
        rises++;
        if (dvp_f.cam_vsync) hi++; else lo++;
        if (!dvp_f.cam_vsync && prev_vs) begin
          falls++;
          if (since_href !== 1) fall_bad++;
        end
        if (dvp_f.cam_href) begin
          if (dvp_f.cam_data !== (par ? 8'hC3 : 8'hA5)) data_bad++;
          par = ~par;
          since_href = 0;
        end else begin
          par = 1'b0;
          since_href++;
        end
        prev_vs = dvp_f.cam_vsync;
      end
      prev_pf = dvp_f.cam_pclk;
      if (frame_done_f) begin
        fd++;
        if (fd == 256) cont_f = 1'b0;
      end
      if (fd < 257 && !busy_f) busy_gap++;
      if (fd == 257 && !busy_f) begin to = 1'b0; break; end
    end
    total++;
    if (to) begin bad++; $display("FAIL cont_timeout got=%0d_frames want=257", fd); end
    total++;
    if (busy_gap !== 0) begin bad++; $display("FAIL cont_idle_gap got=%0d want=0", busy_gap); end
    total++;
    if (rises !== 257 * 37) begin bad++; $display("FAIL cont_pclk_rises got=%0d want=%0d", rises, 257 * 37); end
    total++;
    if (hi !== 257 * 36 || lo !== 257) begin bad++; $display("FAIL cont_vsync_env got=hi%0d/lo%0d want=hi%0d/lo257", hi, lo, 257 * 36); end
    total++;
    if (falls !== 257 || fall_bad !== 0) begin bad++; $display("FAIL cont_vsync_fall got=%0d_falls/%0d_misplaced want=257/0", falls, fall_bad); end
    total++;
    if (data_bad !== 0) begin bad++; $display("FAIL cont_bytes got=%0d_mismatches want=0", data_bad); end
    total++;
    if (frame_count_f !== 8'd1) begin bad++; $display("FAIL cont_wrap got=%0d want=1", frame_count_f); end
  endtask

  task automatic test_reset_midline();
    int fd_cyc; int nb; int first; bit found; bit to; logic [7:0] o, e;
    mode = 2'd0; color565 = 16'h3C5A; green_top = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (obs.size() >= 10 && dvp.cam_href) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL rst_reach_line got=not_found want=href"); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, frame_done, dvp.cam_pclk, dvp.cam_vsync, dvp.cam_href, dvp.cam_data} !== 13'h0) begin
      bad++;
      $display("FAIL rst_outputs got=%b want=0", {busy, frame_done, dvp.cam_pclk, dvp.cam_vsync, dvp.cam_href, dvp.cam_data});
    end
    total++;
    if (frame_count !== 8'h00) begin bad++; $display("FAIL rst_count got=%0d want=0", frame_count); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    obs.delete(); exp_q.delete();
    push_frame(2'd0, 16'h3C5A, 8'h00);
    start_and_wait(fd_cyc, to);
    total++;
    if (to || fd_cyc !== 590) begin bad++; $display("FAIL rst_fresh_latency got=%0d want=590", fd_cyc); end
    total++;
    if (frame_count !== 8'd1) begin bad++; $display("FAIL rst_fresh_count got=%0d want=1", frame_count); end
    nb = 0; first = -1;
    total++;
    if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL rst_fresh_len got=%0d want=%0d", obs.size(), exp_q.size()); end
    for (int i = 0; obs.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin nb++; if (first < 0) first = i; end
    end
    total++;
    if (nb !== 0) begin bad++; $display("FAIL rst_fresh_bytes got=%0d_mismatches(first@%0d) want=0", nb, first); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rst_f = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    rst_f = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_solid();
    test_plant();
    test_bars();
    test_midframe_inputs();
    test_ena_freeze();
    test_continuous();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ov7670_frame_source.md
Name: ov7670_frame_source

Overview:
- Synthetic OV7670-style DVP transmitter. It drives PCLK, VSYNC, HREF and D[7:0] with RGB565 test frames.
- Used for in-system self-test and bench loopback of the camera capture path and the downstream feature/BNN chain, without a physical camera.
- Sits on the board-side pins in place of the OV7670, or feeds the capture logic internally when self-test is selected.

Parameters:
- H_ACTIVE, 16: pixels per line; must be a power of 2, at least 8. A line carries 2*H_ACTIVE bytes.
- V_ACTIVE, 8: active lines per frame; range 1..255.
- H_BLANK, 4: byte ticks with HREF low after each active line.
- VSYNC_W, 3: byte ticks in the VSYNC phase.
- V_BACK, 2: byte ticks between the VSYNC phase and the first line.
- V_FRONT, 2: byte ticks after the last line's blanking.
- VS_MODE, 0: 0 = VSYNC is a pulse during the VSYNC phase only (OV7670 native); 1 = VSYNC is high from VSYNC-phase start until V_FRONT entry, enveloping the active region.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ena  in  1  clock enable; low freezes all state and outputs
- start  in  1  single-frame request; sampled only in IDLE
- continuous  in  1  when high at frame end, the next frame starts immediately
- mode  in  2  pattern: 0 solid, 1 colour bars, 2 plant, 3 ramp
- color565  in  16  solid/background colour
- green_top  in  8  first plant row in mode 2
- cam_pclk  out  1  pixel clock, clk/2 while busy
- cam_vsync  out  1  frame sync
- cam_href  out  1  line valid
- cam_data  out  8  pixel byte
- busy  out  1  high from frame start until return to IDLE
- frame_done  out  1  one-clk pulse at the end of every frame
- frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (async, any time including mid-frame): state IDLE; every output 0 on the same edge; counters cleared.
- States: IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT.
- IDLE -> VSYNC when start=1 and ena=1. On the next clk: busy=1, cam_pclk=0, mode/color565/green_top latched for the whole frame.
- start while busy is ignored. Input changes mid-frame have no effect.
- Byte tick = a clk where ena=1 and cam_pclk=1.
  - While busy, cam_pclk toggles every enabled clk.
  - State, counters, cam_vsync, cam_href and cam_data update only on byte ticks, so they change as cam_pclk falls and are stable at its rising edge.
  - Each phase lasts exactly (tick count)*2 enabled clks.
- Sequence:
  - VSYNC for VSYNC_W ticks, then VBACK for V_BACK ticks.
  - Then V_ACTIVE repetitions of LINE (2*H_ACTIVE ticks, href=1) followed by HBLANK (H_BLANK ticks, href=0).
  - Then VFRONT for V_FRONT ticks.
- cam_vsync:
  - VS_MODE 0: 1 only in VSYNC.
  - VS_MODE 1: 1 in VSYNC, VBACK, LINE and HBLANK; falls on VFRONT entry.
- cam_data:
  - 0 outside LINE.
  - In LINE: even byte = pixel[15:8], odd byte = pixel[7:0] (RRRRRGGG then GGGBBBBB).
- Pixel value (col = pixel index 0..H_ACTIVE-1, row = 0..V_ACTIVE-1):
  - mode 0: color565.
  - mode 1: bar = top 3 bits of col. Bars 0..7 are FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - mode 2: 07E0 if row >= green_top, else color565.
  - mode 3: {row[4:0], col[5:0] zero-extended, 5'b0}.
- Frame end (last VFRONT tick):
  - frame_done=1 for one clk and frame_count increments.
  - If continuous=1, go straight to VSYNC with inputs re-latched, no gap, cam_pclk keeps toggling.
  - Otherwise go to IDLE with busy=0 and cam_pclk=0.
- Frame length with defaults: 3+2+8*(32+4)+2 = 295 ticks = 590 enabled clks.
- ena=0 mid-frame: cam_pclk and all outputs hold their value; timing resumes exactly where it stopped.
- green_top >= V_ACTIVE: the whole frame is background. green_top=0: the whole frame is green.

Test Plan:
- Reset release, then start with mode 0 and color565=F800 (default parameters). Required:
  - 8 HREF pulses, each 32 bytes alternating F8, 00 at cam_pclk rising edges.
  - 295 cam_pclk rising edges in total.
  - frame_done exactly 590 clks after busy rises.
  - busy=0 and frame_count=1 afterwards.
- mode 2, green_top=5, color565=0000. Required: rows 0-4 all 00 bytes; rows 5-7 bytes 07, E0 repeating.
- mode 1 with H_ACTIVE=16. Required: bytes per line are FF,FF ×2, FF,E0 ×2, …, 00,00 ×2; vsync pulse is 3 ticks wide (VS_MODE 0).
- VS_MODE 1 with continuous=1 for 257 frames. Required:
  - vsync falls at each VFRONT entry.
  - No IDLE gap between frames.
  - frame_count wraps to 1 after 257 frames.
- start pulse, mode, and color565 toggled mid-frame. Required: the current frame is unchanged and the new colour appears on the next frame only.
- ena low for 7 clks mid-line. Required: outputs frozen, byte sequence continuous afterwards.
- rst pulsed mid-line. Required: all outputs 0 immediately; a start after release begins a fresh frame with frame_count=0.
